// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, segment constants and scan states for the display scan controller
package display_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    // Segment order is {a,b,c,d,e,f,g}, active-high
    localparam seg_t SEG_0   = 7'b1111110;
    localparam seg_t SEG_1   = 7'b0110000;
    localparam seg_t SEG_2   = 7'b1101101;
    localparam seg_t SEG_3   = 7'b1111001;
    localparam seg_t SEG_4   = 7'b0110011;
    localparam seg_t SEG_5   = 7'b1011011;
    localparam seg_t SEG_6   = 7'b1011111;
    localparam seg_t SEG_7   = 7'b1110000;
    localparam seg_t SEG_8   = 7'b1111111;
    localparam seg_t SEG_9   = 7'b1111011;
    localparam seg_t SEG_OFF = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GUARD
    } scan_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to 7-segment decoder, non-BCD codes are dark
import display_pkg::*;

module bcd_to_7seg (
    input  bcd_t bcd,
    output seg_t seg
);

    // Table lookup; codes 10-15 stay dark so a corrupted digit never lights garbage
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed 7-segment scan with double-buffered frame and blanking guard
import display_pkg::*;

module display_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lzb_en,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      load_ack,
    output logic                      frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    scan_state_t               state, state_nxt;
    logic [IW-1:0]             idx, idx_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic [4*NUM_DIGITS-1:0]   active, active_nxt, pending, pending_nxt;
    logic [NUM_DIGITS-1:0]     active_dp, active_dp_nxt, pending_dp, pending_dp_nxt;
    logic                      pend_valid, pend_valid_nxt;
    logic                      wrap, xfer, zero_run;
    logic [NUM_DIGITS-1:0]     blank;
    bcd_t                      digit_sel;
    logic                      dp_sel, blank_sel;
    seg_t                      seg_dec;

    // Scan sequencing: slot counter, digit index and frame wrap detection
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        wrap      = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SHOW;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
                SHOW: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == SHOW_LAST) state_nxt = GUARD;
                end
                GUARD: begin
                    if (cnt == SLOT_LAST) begin
                        state_nxt = SHOW;
                        cnt_nxt   = '0;
                        if (idx == IDX_LAST) begin
                            idx_nxt = '0;
                            wrap    = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Double buffer: loads park in pending, promoted only in IDLE or at the frame wrap so a frame never tears
    always_comb begin
        xfer           = ((state == IDLE) && pend_valid) || (wrap && (pend_valid || load));
        active_nxt     = active;
        active_dp_nxt  = active_dp;
        pending_nxt    = pending;
        pending_dp_nxt = pending_dp;
        pend_valid_nxt = pend_valid;
        if (xfer) begin
            active_nxt     = load ? digits_in : pending;
            active_dp_nxt  = load ? dp_in : pending_dp;
            pend_valid_nxt = 1'b0;
        end else if (load) begin
            pending_nxt    = digits_in;
            pending_dp_nxt = dp_in;
            pend_valid_nxt = 1'b1;
        end
    end

    // Leading-zero mask from the top digit down; digit 0 always stays lit
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (active_nxt[4*i +: 4] == 4'd0);
            blank[i] = lzb_en & zero_run & (i != 0);
        end
    end

    // Select the digit about to be shown so the decoder sees the frame as it will be after this edge
    always_comb begin
        digit_sel = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                digit_sel = active_nxt[4*i +: 4];
                dp_sel    = active_dp_nxt[i];
                blank_sel = blank[i];
            end
        end
    end

    bcd_to_7seg u_dec (
        .bcd (digit_sel),
        .seg (seg_dec)
    );

    // State, frame buffers and registered pin outputs, all cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            active     <= '0;
            active_dp  <= '0;
            pending    <= '0;
            pending_dp <= '0;
            pend_valid <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= 1'b0;
            an         <= '0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            active     <= active_nxt;
            active_dp  <= active_dp_nxt;
            pending    <= pending_nxt;
            pending_dp <= pending_dp_nxt;
            pend_valid <= pend_valid_nxt;
            load_ack   <= xfer;
            frame_done <= wrap;
            if (state_nxt == SHOW) begin
                seg <= blank_sel ? SEG_OFF : seg_dec;
                dp  <= dp_sel;
                an  <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nxt;
            end else begin
                seg <= SEG_OFF;
                dp  <= 1'b0;
                an  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - scoreboard bench for display_scan_controller against a time-based reference model
module tb_display_scan_controller;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          load;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic          lzb_en;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          load_ack;
    logic          frame_done;

    display_scan_controller #(
        .NUM_DIGITS   (N),
        .CLK_DIV      (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .lzb_en     (lzb_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .load_ack   (load_ack),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] TBL [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    int vectors = 0;
    int miscompares = 0;
    logic [13:0] exp_q [$];

    // Reference model: position in the scan is derived from elapsed cycles since enable
    bit          running = 0;
    int          t = 0;
    logic [15:0] m_act = 0, m_pend = 0;
    logic [3:0]  m_act_dp = 0, m_pend_dp = 0;
    bit          m_pv = 0;

    function automatic logic [13:0] expected(input bit lz, input bit ack, input bit fd);
        logic [6:0] s;
        logic       d;
        logic [3:0] a;
        logic [3:0] code;
        int         pos, di;
        s = 7'b0; d = 1'b0; a = 4'b0;
        if (running) begin
            pos = t % DIV;
            di  = (t / DIV) % N;
            if (pos < DIV - BLK) begin
                a    = 4'(1 << di);
                code = 4'(m_act >> (4 * di));
                d    = m_act_dp[di];
                if (!(lz && di > 0 && (m_act >> (4 * di)) == 16'd0))
                    s = (code < 4'd10) ? TBL[code] : 7'b0;
            end
        end
        return {s, d, a, ack, fd};
    endfunction

    task automatic step(input bit en, input bit ld, input logic [15:0] d, input logic [3:0] p, input bit lz);
        bit wrap, xfer, idle_xfer;
        enable = en; load = ld; digits_in = d; dp_in = p; lzb_en = lz;
        wrap = 0;
        idle_xfer = !running && m_pv;
        if (!en) begin
            running = 0;
        end else if (!running) begin
            running = 1; t = 0;
        end else begin
            t++;
            wrap = (t % FRAME) == 0;
        end
        xfer = idle_xfer || (wrap && (m_pv || ld));
        if (xfer) begin
            m_act    = ld ? d : m_pend;
            m_act_dp = ld ? p : m_pend_dp;
            m_pv     = 0;
        end else if (ld) begin
            m_pend = d; m_pend_dp = p; m_pv = 1;
        end
        exp_q.push_back(expected(lz, xfer, wrap));
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic run(input int n, input bit en, input bit lz);
        for (int i = 0; i < n; i++) step(en, 1'b0, digits_in, dp_in, lz);
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({seg, dp, an, load_ack, frame_done} !== 14'd0) begin
            miscompares++;
            $display("FAIL %s: got seg=%b dp=%b an=%b ack=%b fd=%b, want all zero",
                     name, seg, dp, an, load_ack, frame_done);
        end
    endtask

    // Monitor: one expected output word per clock, compared mid-cycle
    always @(negedge clk) begin
        logic [13:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {seg, dp, an, load_ack, frame_done};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL scan_out @%0t: got seg=%b dp=%b an=%b ack=%b fd=%b, want seg=%b dp=%b an=%b ack=%b fd=%b",
                         $time, g[13:7], g[6], g[5:2], g[1], g[0], e[13:7], e[6], e[5:2], e[1], e[0]);
            end
        end
    end

    initial begin
        reset = 1'b0; enable = 1'b0; load = 1'b0; digits_in = 16'h0; dp_in = 4'h0; lzb_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk); #1 reset = 1'b1;

        // Reset/enable: idle with outputs dark, then first scan of an all-zero frame
        run(20, 1'b0, 1'b0);
        run(40, 1'b1, 1'b0);

        // Load in IDLE, then full scan of 0x1234
        run(2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
        run(1, 1'b0, 1'b0);
        run(12, 1'b1, 1'b0);

        // Mid-frame load holds until the boundary
        step(1'b1, 1'b1, 16'h5678, 4'b0001, 1'b0);
        run(50, 1'b1, 1'b0);

        // Leading-zero blanking on 0x0070, then 0x0000
        run(1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h0070, 4'b0000, 1'b1);
        run(36, 1'b1, 1'b1);
        step(1'b1, 1'b1, 16'h0000, 4'b0010, 1'b1);
        run(40, 1'b1, 1'b1);

        // Enable drop during digit 2, then restart at digit 0
        run(1, 1'b0, 1'b0);
        run(18, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);
        run(20, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a SHOW slot
        @(negedge clk); #1 reset = 1'b0;
        #1 check_zero("async_reset");
        running = 0; t = 0; m_act = 0; m_pend = 0; m_act_dp = 0; m_pend_dp = 0; m_pv = 0;
        @(posedge clk); #1 check_zero("reset_after_edge");
        @(negedge clk); #1 reset = 1'b1;

        // Non-BCD codes, then two loads in one frame
        step(1'b0, 1'b1, 16'hF00A, 4'b1001, 1'b0);
        run(36, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h1111, 4'b0000, 1'b0);
        run(3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h9876, 4'b0110, 1'b0);
        run(70, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
            if ($urandom_range(0, 3) == 0) d = d & 16'h0F0F;
            step(($urandom_range(0, 60) != 0), ($urandom_range(0, 12) == 0), d, 4'($urandom),
                 ($urandom_range(0, 1) == 1));
        end

        run(4, 1'b0, 1'b0);
        @(negedge clk); #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
